// File: rtl/aclk_defs_pkg.sv
// Shared key codes, controller state encoding and 24-hour time limits for the alarm-clock keypad path.
// Constants only; no latency and no backpressure.
package aclk_defs;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ENTRY = 1'b1;

  localparam logic [3:0] MAX_MS_HR       = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN      = 4'd5;
  localparam logic [3:0] MAX_DIGIT       = 4'd9;

  localparam logic [2:0] DIGIT_CNT_FULL = 3'd4;

endpackage

// File: rtl/aclk_key_buffer.sv
// Four-digit BCD shift register with entry counter; start loads the first digit, shift appends one.
// One-cycle update latency; no backpressure, the controller decides when to start, shift or clear.
module aclk_key_buffer
  import aclk_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       start,
  input  logic       shift,
  input  logic [3:0] digit,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [2:0] digit_cnt
);

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      ms_hr     <= 4'h0;
      ls_hr     <= 4'h0;
      ms_min    <= 4'h0;
      ls_min    <= 4'h0;
      digit_cnt <= 3'd0;
    end else if (start) begin
      ms_hr     <= 4'h0;
      ls_hr     <= 4'h0;
      ms_min    <= 4'h0;
      ls_min    <= digit;
      digit_cnt <= 3'd1;
    end else if (shift && digit_cnt < DIGIT_CNT_FULL) begin
      ms_hr     <= ls_hr;
      ls_hr     <= ms_min;
      ms_min    <= ls_min;
      ls_min    <= digit;
      digit_cnt <= digit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/aclk_key_entry_ctrl.sv
// Keypad entry sequencer: collects HH:MM digits, validates them and pulses an alarm or time load.
// Outputs registered, effects visible one edge after the key; no backpressure, keys are never stalled.
module aclk_key_entry_ctrl
  import aclk_defs::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] key_buffer_ms_hr,
  output logic [3:0] key_buffer_ls_hr,
  output logic [3:0] key_buffer_ms_min,
  output logic [3:0] key_buffer_ls_min,
  output logic       load_new_alarm,
  output logic       load_new_time,
  output logic       show_new_time,
  output logic       entry_error
);

  localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_SEC);

  logic [0:0] state;
  logic [3:0] timer;
  logic [2:0] digit_cnt;
  logic       is_digit, is_commit, is_clear, key_accepted;
  logic       commit_ok, timeout_hit;
  logic       buf_clr, buf_start, buf_shift;

  assign is_digit     = key_code <= MAX_DIGIT;
  assign is_commit    = (key_code == KEY_ALARM) || (key_code == KEY_TIME);
  assign is_clear     = key_code == KEY_CLEAR;
  assign key_accepted = key_valid && (is_digit || is_commit || is_clear);

  assign commit_ok = (digit_cnt == DIGIT_CNT_FULL)
                  && (key_buffer_ms_hr  <= MAX_MS_HR)
                  && (key_buffer_ls_hr  <= MAX_DIGIT)
                  && (key_buffer_ms_min <= MAX_MS_MIN)
                  && (key_buffer_ls_min <= MAX_DIGIT)
                  && ((key_buffer_ms_hr < MAX_MS_HR) || (key_buffer_ls_hr <= MAX_LS_HR_AT_20));

  // A key in the same cycle as one_second wins, so the timeout only fires on key-free ticks.
  assign timeout_hit = (state == ENTRY) && one_second && !key_accepted
                    && (timer + 4'd1 == TIMEOUT_LIMIT);

  always_comb begin
    buf_clr   = 1'b0;
    buf_start = 1'b0;
    buf_shift = 1'b0;
    if (state == IDLE) begin
      buf_start = key_valid && is_digit;
    end else if (key_accepted) begin
      buf_shift = is_digit;
      buf_clr   = is_clear || (is_commit && !commit_ok);
    end else begin
      buf_clr = timeout_hit;
    end
  end

  aclk_key_buffer u_key_buffer (
    .clock     (clock),
    .reset     (reset),
    .clr       (buf_clr),
    .start     (buf_start),
    .shift     (buf_shift),
    .digit     (key_code),
    .ms_hr     (key_buffer_ms_hr),
    .ls_hr     (key_buffer_ls_hr),
    .ms_min    (key_buffer_ms_min),
    .ls_min    (key_buffer_ls_min),
    .digit_cnt (digit_cnt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      timer          <= 4'd0;
      load_new_alarm <= 1'b0;
      load_new_time  <= 1'b0;
      entry_error    <= 1'b0;
    end else begin
      load_new_alarm <= 1'b0;
      load_new_time  <= 1'b0;
      entry_error    <= 1'b0;
      if (state == IDLE) begin
        timer <= 4'd0;
        if (key_valid && is_digit) state <= ENTRY;
      end else if (key_accepted) begin
        timer <= 4'd0;
        if (is_commit) begin
          state <= IDLE;
          if (!commit_ok)                 entry_error    <= 1'b1;
          else if (key_code == KEY_ALARM) load_new_alarm <= 1'b1;
          else                            load_new_time  <= 1'b1;
        end else if (is_clear) begin
          state <= IDLE;
        end
      end else if (timeout_hit) begin
        state <= IDLE;
        timer <= 4'd0;
      end else if (one_second) begin
        timer <= timer + 4'd1;
      end
    end
  end

  assign show_new_time = (state == ENTRY);

endmodule

// File: tb/tb_aclk_key_entry_ctrl.sv
// Bench for aclk_key_entry_ctrl: directed keypad scenarios followed by random traffic, every cycle
// compared against a time-arithmetic reference model (HH < 24, MM < 60, four digits entered).
module tb_aclk_key_entry_ctrl;

  localparam int TO = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min;
  logic       load_new_alarm, load_new_time, show_new_time, entry_error;

  int errors = 0;
  int checks = 0;

  // Reference model state: digits oldest-first, count, entry flag, seconds idle.
  int m_dg[4];
  int m_n = 0;
  bit m_entry = 1'b0;
  int m_tmr = 0;
  bit m_alarm = 1'b0, m_time = 1'b0, m_err = 1'b0;

  aclk_key_entry_ctrl #(.TIMEOUT_SEC(TO)) dut (
    .clock             (clock),
    .reset             (reset),
    .one_second        (one_second),
    .key_valid         (key_valid),
    .key_code          (key_code),
    .key_buffer_ms_hr  (key_buffer_ms_hr),
    .key_buffer_ls_hr  (key_buffer_ls_hr),
    .key_buffer_ms_min (key_buffer_ms_min),
    .key_buffer_ls_min (key_buffer_ls_min),
    .load_new_alarm    (load_new_alarm),
    .load_new_time     (load_new_time),
    .show_new_time     (show_new_time),
    .entry_error       (entry_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_dg[i] = 0;
    m_n = 0;
  endfunction

  function automatic void model_edge(input bit r, input bit kv, input int kc, input bit os);
    int hh, mm;
    m_alarm = 1'b0; m_time = 1'b0; m_err = 1'b0;
    if (!r) begin
      model_clear(); m_entry = 1'b0; m_tmr = 0;
    end else if (!m_entry) begin
      if (kv && kc <= 9) begin
        model_clear(); m_dg[3] = kc; m_n = 1; m_entry = 1'b1; m_tmr = 0;
      end
    end else if (kv && kc <= 12) begin
      m_tmr = 0;
      if (kc <= 9) begin
        if (m_n < 4) begin
          for (int i = 0; i < 3; i++) m_dg[i] = m_dg[i+1];
          m_dg[3] = kc; m_n++;
        end
      end else if (kc == 10 || kc == 11) begin
        hh = m_dg[0] * 10 + m_dg[1];
        mm = m_dg[2] * 10 + m_dg[3];
        if (m_n == 4 && hh < 24 && mm < 60) begin
          if (kc == 10) m_alarm = 1'b1; else m_time = 1'b1;
        end else begin
          m_err = 1'b1; model_clear();
        end
        m_entry = 1'b0;
      end else begin
        model_clear(); m_entry = 1'b0;
      end
    end else if (os) begin
      m_tmr++;
      if (m_tmr == TO) begin
        model_clear(); m_entry = 1'b0; m_tmr = 0;
      end
    end
  endfunction

  task automatic step(input bit r, input bit kv, input int kc, input bit os);
    @(negedge clock);
    reset = r; key_valid = kv; key_code = 4'(kc); one_second = os;
    @(posedge clock);
    model_edge(r, kv, kc, os);
    #1;
    chk("buffer", {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min},
        16'({4'(m_dg[0]), 4'(m_dg[1]), 4'(m_dg[2]), 4'(m_dg[3])}));
    chk("pulses", {13'd0, load_new_alarm, load_new_time, entry_error},
        {13'd0, m_alarm, m_time, m_err});
    chk("show_new_time", {15'd0, show_new_time}, {15'd0, m_entry});
  endtask

  task automatic key(input int kc);
    step(1'b1, 1'b1, kc, 1'b0);
  endtask

  task automatic idle(input bit os);
    step(1'b1, 1'b0, 0, os);
  endtask

  initial begin
    bit r, kv, os;
    int kc;

    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 5, 1'b1);

    key(0); key(7); key(3); key(0); key(10);
    chk("alarm_0730_buffer", {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min}, 16'h0730);
    chk("alarm_0730_pulse", {15'd0, load_new_alarm}, 16'd1);
    idle(1'b0);
    chk("alarm_pulse_one_cycle", {15'd0, load_new_alarm}, 16'd0);

    key(2); key(3); key(5); key(9); key(11);
    key(2); key(4); key(0); key(0); key(10);
    chk("bad_2400_error", {15'd0, entry_error}, 16'd1);

    key(1); key(2); key(10);
    key(1); key(2); key(3); key(4); key(5); key(11);
    chk("fifth_digit_ignored", {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min}, 16'h1234);

    // Back-to-back: key in the same cycle as the load pulse starts a fresh entry.
    key(1); key(9); key(5); key(9); key(11); key(2); idle(1'b0);

    key(1); idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b1);
    chk("timeout_idle", {15'd0, show_new_time}, 16'd0);
    key(1); idle(1'b1); idle(1'b1); step(1'b1, 1'b1, 2, 1'b1);
    chk("key_beats_timeout", {15'd0, show_new_time}, 16'd1);
    idle(1'b0); key(12);

    key(1); key(5); key(12);
    key(1); idle(1'b1); idle(1'b1); key(14); key(15); idle(1'b1);
    key(1); key(14); key(13); key(2);

    key(0); key(9); step(1'b0, 1'b0, 0, 1'b0);
    chk("reset_mid_entry", {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min}, 16'h0000);
    key(10); key(11); key(12); key(13);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      kv = ($urandom_range(0, 2) == 0);
      kc = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      if (m_entry && m_n < 2 && kc <= 9) kc = $urandom_range(0, 2);
      os = ($urandom_range(0, 3) == 0);
      step(r, kv, kc, os);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aclk_key_entry_ctrl.md
Name: aclk_key_entry_ctrl

Overview:
- Keypad entry sequencer for the 24-hour alarm clock.
- Collects four BCD digits from the keypad into a key buffer and validates them as a 24-hour time.
- On the ALARM key it issues a one-cycle load_new_alarm to the alarm register; on the TIME key it issues load_new_time to the time counter.
- Drives show_new_time to the display mux while entry is in progress, and abandons entry on CLEAR, on an invalid time, or after an inactivity timeout.

Parameters:
- TIMEOUT_SEC, 10: whole seconds without a key in ENTRY before entry is abandoned; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- one_second  in  1  one-cycle pulse, once per second.
- key_valid  in  1  one-cycle strobe; key_code is valid when it is high.
- key_code  in  4  0-9 digit, 4'hA ALARM, 4'hB TIME, 4'hC CLEAR; 4'hD-4'hF are reserved.
- key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min  out  4 each  entered digits; feed both the alarm-register and time-counter load inputs.
- load_new_alarm  out  1  one-cycle commit pulse to the alarm register.
- load_new_time  out  1  one-cycle commit pulse to the time counter.
- show_new_time  out  1  high while entry is in progress.
- entry_error  out  1  one-cycle pulse on a rejected commit.

Behaviour:
- Reset (reset==0 at an edge): state IDLE, digit_cnt 0, timer 0, all buffer digits 4'h0, all pulse outputs 0, show_new_time 0. Reset takes priority over every other input.
- All outputs are registered. A key accepted at edge N produces its effects (buffer, pulses, state) visible after edge N.
- States:
  - IDLE: buffer holds the last entered value.
  - ENTRY: show_new_time=1.
- IDLE, digit d:
  - ms_hr, ls_hr, ms_min cleared to 0; ls_min<=d.
  - digit_cnt<=1; state ENTRY.
- IDLE, ALARM/TIME/CLEAR/reserved key: ignored; no outputs change.
- ENTRY, digit d with digit_cnt<4:
  - left shift: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=d.
  - digit_cnt increments.
- ENTRY, digit with digit_cnt==4: ignored; the buffer is not changed. The inactivity timer still restarts.
- ENTRY, ALARM or TIME key:
  - Commit is valid only when all of the following hold: digit_cnt==4, ms_hr<=2, ls_hr<=9, ms_min<=5, ls_min<=9, and (ms_hr<2 or ls_hr<=3).
  - Valid commit: the matching load pulse is high for exactly one cycle; the buffer is held unchanged during and after the pulse; state returns to IDLE.
  - Invalid commit: entry_error is high for one cycle, the buffer is cleared to 0, no load pulse is issued, and state returns to IDLE.
- ENTRY, CLEAR key: buffer cleared to 0; state IDLE; no error pulse.
- ENTRY, reserved key: ignored; the timer is not restarted.
- Inactivity timer (4 bits):
  - Restarts to 0 on every accepted digit/ALARM/TIME/CLEAR key.
  - Increments on one_second while in ENTRY.
  - When it would reach TIMEOUT_SEC: buffer cleared, state IDLE, no error pulse.
- Simultaneous key_valid and one_second: the key wins and the timer restarts to 0.
- load_new_alarm, load_new_time and entry_error are mutually exclusive and never high on consecutive cycles from a single key.
- A key arriving in the cycle a load pulse is high is processed normally from IDLE.
- Reset asserted mid-entry: abandons entry the same edge; no pulse is issued.

Decomposition:
- Shared package aclk_defs:
  - key code constants KEY_ALARM=4'hA, KEY_TIME=4'hB, KEY_CLEAR=4'hC.
  - state encoding IDLE/ENTRY.
  - time limit constants MAX_MS_HR=2, MAX_LS_HR_AT_20=3, MAX_MS_MIN=5.
- One sub-module, aclk_key_buffer: the 4x4-bit shift/clear register with a digit counter. The controller FSM, timer and validation stay in the top level.

Test Plan:
- Reset low for 2 cycles, then digits 0,7,3,0 then ALARM -> buffer 0,7,3,0; load_new_alarm high exactly 1 cycle, load_new_time 0; show_new_time falls with the pulse.
- Digits 2,3,5,9 then TIME -> load_new_time single pulse with buffer 2,3,5,9; digits 2,4,0,0 then ALARM -> entry_error pulse, buffer 0,0,0,0, no load.
- Digits 1,2 then ALARM -> entry_error (digit_cnt 2); digits 1,2,3,4,5 then TIME -> buffer 1,2,3,4 and load_new_time pulse (fifth digit ignored).
- TIMEOUT_SEC=3: digit 1, then 3 one_second pulses with no key -> IDLE, buffer 0, no pulses. Repeat with a digit on the same cycle as the 3rd pulse -> still in ENTRY.
- Digits 1,5 then CLEAR -> IDLE, buffer 0, no error. Reserved key 4'hE in ENTRY -> no state, buffer or timer change.
- Digits 0,9 then reset low on the next edge -> all outputs 0 that edge. ALARM key while in IDLE -> no output change.
